// File: rtl/axi_lite_master_bridge_if.sv
// rtl/axi_lite_master_bridge_if.sv - core request/response and AXI4-Lite channel bundle for the bridge
interface axi_lite_master_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic [2:0]  m_arprot;
    logic        m_arready;

    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic [2:0]  m_awprot;
    logic        m_awready;

    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;

    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output m_araddr, m_arvalid, m_arprot,
        input  m_arready,
        input  m_rdata, m_rresp, m_rvalid,
        output m_rready,
        output m_awaddr, m_awvalid, m_awprot,
        input  m_awready,
        output m_wdata, m_wstrb, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  m_araddr, m_arvalid, m_arprot,
        output m_arready,
        output m_rdata, m_rresp, m_rvalid,
        input  m_rready,
        input  m_awaddr, m_awvalid, m_awprot,
        output m_awready,
        input  m_wdata, m_wstrb, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// rtl/axi_lite_master_bridge.sv - single-outstanding core MMIO to AXI4-Lite master bridge with timeout
module axi_lite_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    axi_lite_master_bridge_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        aw_done;
    logic        w_done;
    logic [31:0] tmo_cnt;

    logic        accept;
    logic        busy;
    logic        timed_out;

    assign accept    = bus.req_valid && bus.req_ready;
    assign busy      = (state == RD_ADDR) || (state == RD_DATA) ||
                       (state == WR_REQ)  || (state == WR_RESP);
    assign timed_out = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A response arriving on the expiry cycle is taken in preference to the timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = bus.req_write ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (timed_out) begin
                    next_state = RESP;
                end else if (bus.m_arready) begin
                    next_state = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bus.m_rvalid || timed_out) begin
                    next_state = RESP;
                end
            end
            WR_REQ: begin
                if (timed_out) begin
                    next_state = RESP;
                end else if ((aw_done || bus.m_awready) && (w_done || bus.m_wready)) begin
                    next_state = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.m_bvalid || timed_out) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // IDLE keeps rready/bready high so late responses after a timeout are drained silently.
    always_comb begin
        bus.req_ready  = (state == IDLE) && rstn;
        bus.m_araddr   = addr_q;
        bus.m_arvalid  = (state == RD_ADDR);
        bus.m_arprot   = 3'b000;
        bus.m_rready   = (state == RD_DATA) || ((state == IDLE) && rstn);
        bus.m_awaddr   = addr_q;
        bus.m_awvalid  = (state == WR_REQ) && !aw_done;
        bus.m_awprot   = 3'b000;
        bus.m_wdata    = wdata_q;
        bus.m_wstrb    = wstrb_q;
        bus.m_wvalid   = (state == WR_REQ) && !w_done;
        bus.m_bready   = (state == WR_RESP) || ((state == IDLE) && rstn);
        bus.resp_valid = (state == RESP);
        bus.resp_err   = (state == RESP) && err_q;
        bus.resp_rdata = (state == RESP) ? rdata_q : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            tmo_cnt <= 32'h0;
        end else if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            tmo_cnt <= 32'h0;
        end else begin
            if (busy) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            if (bus.m_awvalid && bus.m_awready) begin
                aw_done <= 1'b1;
            end
            if (bus.m_wvalid && bus.m_wready) begin
                w_done <= 1'b1;
            end
            case (state)
                RD_DATA: begin
                    if (bus.m_rvalid) begin
                        err_q   <= (bus.m_rresp >= 2'b10);
                        rdata_q <= (bus.m_rresp >= 2'b10) ? 32'h0 : bus.m_rdata;
                    end else if (timed_out) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end
                end
                WR_RESP: begin
                    if (bus.m_bvalid) begin
                        err_q <= (bus.m_bresp >= 2'b10);
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end
                end
                RD_ADDR, WR_REQ: begin
                    if (timed_out) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
